// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo_prog
// Single-clock FIFO: FWFT or registered read, programmable almost flags,
// write-through when full, flush, fill level and sticky error flags.
// Rev    : 1.0
// ============================================================================
module sync_fifo_prog #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int FWFT   = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_flush,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  input  logic [CNT_W-1:0]  i_afull_th,
  input  logic [CNT_W-1:0]  i_aempty_th,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic              o_underflow,
  input  logic              i_clr_err
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrptr_q, wrptr_d;
  logic [PTR_W-1:0]  rdptr_q, rdptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              empty, full, rd_acc, wr_acc, wr_do, rd_do;

  assign empty  = (count_q == '0);
  assign full   = (count_q == C_DEPTH);
  assign rd_acc = i_rden & ~empty;
  assign wr_acc = i_wren & (~full | rd_acc);
  // Flush overrides any same-cycle transfer.
  assign wr_do  = wr_acc & ~i_flush;
  assign rd_do  = rd_acc & ~i_flush;

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    count_d = count_q;
    if (i_flush) begin
      wrptr_d = '0;
      rdptr_d = '0;
      count_d = '0;
    end else begin
      if (wr_do) wrptr_d = (wrptr_q == C_PTR_LAST) ? '0 : wrptr_q + C_PTR_ONE;
      if (rd_do) rdptr_d = (rdptr_q == C_PTR_LAST) ? '0 : rdptr_q + C_PTR_ONE;
      if (wr_do && !rd_do)      count_d = count_q + C_CNT_ONE;
      else if (rd_do && !wr_do) count_d = count_q - C_CNT_ONE;
    end
    // New errors win over a same-cycle clear.
    ovf_d = (ovf_q & ~i_clr_err) | (i_wren & ~wr_acc & ~i_flush);
    unf_d = (unf_q & ~i_clr_err) | (i_rden & empty & ~i_flush);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_do) mem_q[wrptr_q] <= i_wrdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_rddata  = mem_q[rdptr_q];
      assign o_rdvalid = ~empty;
    end else begin : g_reg_read
      logic [DATA_W-1:0] rddata_q, rddata_d;
      logic              rdvalid_q, rdvalid_d;

      always_comb begin
        rddata_d  = rddata_q;
        rdvalid_d = rd_do;
        if (rd_do) rddata_d = mem_q[rdptr_q];
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rddata_q  <= '0;
          rdvalid_q <= 1'b0;
        end else begin
          rddata_q  <= rddata_d;
          rdvalid_q <= rdvalid_d;
        end
      end

      assign o_rddata  = rddata_q;
      assign o_rdvalid = rdvalid_q;
    end
  endgenerate

  assign o_full      = full;
  assign o_empty     = empty;
  assign o_alm_full  = (count_q >= i_afull_th);
  assign o_alm_empty = (count_q <= i_aempty_th);
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module : tb_sync_fifo_prog
// Directed table-driven bench for sync_fifo_prog (FWFT DEPTH=16, registered DEPTH=4).
// Rev    : 1.0
// ============================================================================
module tb_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  // FWFT instance
  logic        flush = 0, wren = 0, rden = 0, clr = 0;
  logic [31:0] wdata = 0;
  logic [4:0]  afull_th = 5'd14, aempty_th = 5'd2;
  logic [31:0] rddata;
  logic        rdvalid, full, empty, afull, aempty, ovf, unf;
  logic [4:0]  count;
  // Registered-read instance
  logic        b_flush = 0, b_wren = 0, b_rden = 0, b_clr = 0;
  logic [31:0] b_wdata = 0;
  logic [31:0] b_rddata;
  logic        b_rdvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [2:0]  b_count;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_W(32), .DEPTH(16), .FWFT(1)) dut (
    .clk(clk), .rstn(rstn), .i_flush(flush), .i_wren(wren), .i_wrdata(wdata),
    .i_rden(rden), .o_rddata(rddata), .o_rdvalid(rdvalid),
    .i_afull_th(afull_th), .i_aempty_th(aempty_th), .o_full(full), .o_empty(empty),
    .o_alm_full(afull), .o_alm_empty(aempty), .o_count(count),
    .o_overflow(ovf), .o_underflow(unf), .i_clr_err(clr)
  );

  sync_fifo_prog #(.DATA_W(32), .DEPTH(4), .FWFT(0)) dut_b (
    .clk(clk), .rstn(rstn), .i_flush(b_flush), .i_wren(b_wren), .i_wrdata(b_wdata),
    .i_rden(b_rden), .o_rddata(b_rddata), .o_rdvalid(b_rdvalid),
    .i_afull_th(3'd3), .i_aempty_th(3'd1), .o_full(b_full), .o_empty(b_empty),
    .o_alm_full(b_afull), .o_alm_empty(b_aempty), .o_count(b_count),
    .o_overflow(b_ovf), .o_underflow(b_unf), .i_clr_err(b_clr)
  );

  typedef struct {
    logic        wren, rden, flush, clr;
    logic [31:0] wdata;
    int          exp_cnt;
    logic [31:0] exp_data;
    logic        chk_data, exp_ovf, exp_unf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic w, input logic r, input logic f, input logic c,
                     input logic [31:0] d, input int cnt, input logic [31:0] ed,
                     input logic cd, input logic eo, input logic eu);
    vec_t v;
    v.wren = w; v.rden = r; v.flush = f; v.clr = c; v.wdata = d;
    v.exp_cnt = cnt; v.exp_data = ed; v.chk_data = cd; v.exp_ovf = eo; v.exp_unf = eu;
    tbl.push_back(v);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic f, input logic c,
                       input logic [31:0] d);
    wren = w; rden = r; flush = f; clr = c; wdata = d;
  endtask

  initial begin
    vec_t v;
    // Fill 1..16, overflow, clear
    for (int i = 1; i <= 16; i++) add(1, 0, 0, 0, i, i, 32'h1, 1, 0, 0);
    add(1, 0, 0, 0, 32'h11, 16, 32'h1, 1, 1, 0);
    add(0, 0, 0, 1, 0, 16, 32'h1, 1, 0, 0);
    // Drain in order
    for (int j = 1; j <= 16; j++) add(0, 1, 0, 0, 0, 16 - j, j + 1, (j < 16), 0, 0);
    // Write+read on empty: write only, underflow
    add(1, 1, 0, 0, 32'h100, 1, 32'h100, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1, 32'h100, 1, 0, 0);
    for (int k = 1; k <= 15; k++) add(1, 0, 0, 0, 32'h100 + k, 1 + k, 32'h100, 1, 0, 0);
    // Write-through at full across pointer wrap
    for (int k = 0; k < 20; k++) add(1, 1, 0, 0, 32'h110 + k, 16, 32'h101 + k, 1, 0, 0);
    for (int j = 1; j <= 11; j++) add(0, 1, 0, 0, 0, 16 - j, 32'h114 + j, 1, 0, 0);

    // Reset state, asserted before any edge
    #12;
    chk("rst count", 32'(count), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst rdvalid", 32'(rdvalid), 0);
    chk("rst ovf", 32'(ovf), 0);
    chk("rst unf", 32'(unf), 0);
    chk("rst aempty", 32'(aempty), 1);
    chk("rst afull", 32'(afull), 0);
    chk("rst b_rdvalid", 32'(b_rdvalid), 0);
    chk("rst b_rddata", b_rddata, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.wren, v.rden, v.flush, v.clr, v.wdata);
      step();
      chk($sformatf("v%0d count", i), 32'(count), 32'(v.exp_cnt));
      chk($sformatf("v%0d full", i), 32'(full), 32'(v.exp_cnt == 16));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(v.exp_cnt == 0));
      chk($sformatf("v%0d rdvalid", i), 32'(rdvalid), 32'(v.exp_cnt != 0));
      chk($sformatf("v%0d afull", i), 32'(afull), 32'(v.exp_cnt >= 14));
      chk($sformatf("v%0d aempty", i), 32'(aempty), 32'(v.exp_cnt <= 2));
      chk($sformatf("v%0d ovf", i), 32'(ovf), 32'(v.exp_ovf));
      chk($sformatf("v%0d unf", i), 32'(unf), 32'(v.exp_unf));
      if (v.chk_data) chk($sformatf("v%0d data", i), rddata, v.exp_data);
    end
    drive(0, 0, 0, 0, 0);

    // Live thresholds at count=5
    afull_th = 5'd5;  #1 chk("th afull=5", 32'(afull), 1);
    afull_th = 5'd6;  #1 chk("th afull=6", 32'(afull), 0);
    aempty_th = 5'd5; #1 chk("th aempty=5", 32'(aempty), 1);
    aempty_th = 5'd4; #1 chk("th aempty=4", 32'(aempty), 0);
    afull_th = 5'd14; aempty_th = 5'd2;

    // Up to 9, then flush with a concurrent write
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 32'h200 + k);
      step();
    end
    chk("pre-flush count", 32'(count), 9);
    drive(1, 0, 1, 0, 32'hDEAD);
    step();
    chk("flush count", 32'(count), 0);
    chk("flush empty", 32'(empty), 1);
    chk("flush ovf", 32'(ovf), 0);
    drive(1, 0, 0, 0, 32'h77);
    step();
    chk("post-flush head", rddata, 32'h77);
    chk("post-flush count", 32'(count), 1);
    drive(0, 1, 0, 0, 0);
    step();
    chk("drain count", 32'(count), 0);
    step();
    chk("empty read unf", 32'(unf), 1);
    drive(0, 1, 1, 0, 0);
    step();
    chk("flush keeps unf", 32'(unf), 1);
    drive(0, 0, 0, 1, 0);
    step();
    chk("clr unf", 32'(unf), 0);
    chk("clr ovf", 32'(ovf), 0);
    drive(0, 1, 0, 1, 0);
    step();
    chk("clr vs new unf", 32'(unf), 1);

    // Asynchronous reset mid-burst
    drive(1, 0, 0, 0, 32'h300);
    step();
    wdata = 32'h301;
    step();
    chk("burst count", 32'(count), 2);
    #3 rstn = 1'b0;
    #1;
    chk("async count", 32'(count), 0);
    chk("async empty", 32'(empty), 1);
    chk("async rdvalid", 32'(rdvalid), 0);
    chk("async unf", 32'(unf), 0);
    chk("async ovf", 32'(ovf), 0);
    drive(0, 0, 0, 0, 0);
    #1 rstn = 1'b1;
    step();
    chk("post-rst count", 32'(count), 0);

    // Registered read path
    b_wren = 1; b_wdata = 32'hA5;
    step();
    chk("b wr rdvalid", 32'(b_rdvalid), 0);
    chk("b wr count", 32'(b_count), 1);
    b_wren = 0; b_rden = 1;
    step();
    chk("b rd rdvalid", 32'(b_rdvalid), 1);
    chk("b rd data", b_rddata, 32'hA5);
    b_rden = 0;
    step();
    chk("b idle rdvalid", 32'(b_rdvalid), 0);
    chk("b hold data", b_rddata, 32'hA5);
    b_wren = 1; b_wdata = 32'h11;
    step();
    b_wdata = 32'h22;
    step();
    b_wren = 0; b_rden = 1;
    step();
    chk("b rd1 valid", 32'(b_rdvalid), 1);
    chk("b rd1 data", b_rddata, 32'h11);
    step();
    chk("b rd2 valid", 32'(b_rdvalid), 1);
    chk("b rd2 data", b_rddata, 32'h22);
    b_rden = 0; b_wren = 1; b_wdata = 32'h33;
    step();
    b_wren = 0; b_flush = 1; b_rden = 1;
    step();
    chk("b flush valid", 32'(b_rdvalid), 0);
    chk("b flush data", b_rddata, 32'h22);
    chk("b flush count", 32'(b_count), 0);
    chk("b flush unf", 32'(b_unf), 0);
    b_flush = 0; b_rden = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
